// File: rtl/reflex_score.sv
// Reaction-time scorer: times from a stimulus-light rising edge to a fire press in
// BCD milliseconds, and keeps the best (lowest) valid result.
module reflex_score #(
   parameter int unsigned CLKS_PER_MS = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arm_pulse,
   input  logic        light_on,
   input  logic        fire_pulse,
   input  logic        clear_best,
   output logic [11:0] bcd_time,
   output logic [11:0] best_time,
   output logic        valid,
   output logic        false_start,
   output logic        overflow,
   output logic        new_best
);

   localparam int unsigned    PW   = $clog2(CLKS_PER_MS);
   localparam logic [PW-1:0]  TERM = PW'(CLKS_PER_MS - 1);
   localparam logic [11:0]    MAX_BCD = 12'h999;

   typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FAULT} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] prescaler;
   logic          light_d;
   logic          judge;
   logic          start;
   logic          ms_tick;

   assign start   = light_on & ~light_d;
   assign ms_tick = (state_q == TIMING) && (prescaler == TERM);

   // Decimal increment; the caller guarantees the input is below 999.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] d2, d1, d0;
      {d2, d1, d0} = v;
      if (d0 != 4'd9) begin
         d0 = d0 + 4'd1;
      end else begin
         d0 = 4'd0;
         if (d1 != 4'd9) begin
            d1 = d1 + 4'd1;
         end else begin
            d1 = 4'd0;
            d2 = d2 + 4'd1;
         end
      end
      return {d2, d1, d0};
   endfunction

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: default assigned first so no path through this block leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      if (arm_pulse) begin
         state_d = ARMED;
      end else begin
         case (state_q)
            ARMED: begin
               if (fire_pulse)  state_d = FAULT;
               else if (start)  state_d = TIMING;
            end
            TIMING: if (fire_pulse) state_d = DONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler   <= '0;
         light_d     <= 1'b0;
         judge       <= 1'b0;
         bcd_time    <= 12'h000;
         best_time   <= MAX_BCD;
         valid       <= 1'b0;
         false_start <= 1'b0;
         overflow    <= 1'b0;
         new_best    <= 1'b0;
      end else begin
         light_d  <= light_on;
         new_best <= 1'b0;
         judge    <= 1'b0;
         if (arm_pulse) begin
            prescaler   <= '0;
            bcd_time    <= 12'h000;
            valid       <= 1'b0;
            false_start <= 1'b0;
            overflow    <= 1'b0;
         end else begin
            case (state_q)
               ARMED: begin
                  // The start cycle itself is prescaler count 0.
                  if (fire_pulse)  false_start <= 1'b1;
                  else if (start)  prescaler   <= PW'(1);
               end
               TIMING: begin
                  if (fire_pulse) begin
                     valid <= 1'b1;
                     judge <= 1'b1;
                  end else begin
                     prescaler <= ms_tick ? '0 : prescaler + PW'(1);
                     if (ms_tick) begin
                        if (bcd_time == MAX_BCD) overflow <= 1'b1;
                        else                     bcd_time <= bcd_inc(bcd_time);
                     end
                  end
               end
               DONE: begin
                  if (judge && !overflow && (bcd_time < best_time)) begin
                     best_time <= bcd_time;
                     new_best  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (clear_best) begin
            best_time <= MAX_BCD;
            new_best  <= 1'b0;
         end
      end
   end

endmodule
